// File: rtl/multdiv_pkg.sv
// Shared types and helpers for the multi-cycle multiply/divide unit.
// Holds the FSM state encoding, default width, MIN_INT and the magnitude helper.
package multdiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [DEFAULT_WIDTH-1:0] MIN_INT = {1'b1, {(DEFAULT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    // The result is read as unsigned, so MIN_INT maps to 2^(W-1) rather than overflowing.
    function automatic logic [DEFAULT_WIDTH-1:0] twos_mag(input logic [DEFAULT_WIDTH-1:0] v);
        return v[DEFAULT_WIDTH-1] ? -v : v;
    endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
// Latency: combinational, 0 cycles.
// Backpressure: none, pure function of its inputs.
module restoring_div_step
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   rem_cur,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] dvsr,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH:0]   diff;

    always_comb begin
        shifted  = {rem_cur, dvd_bit};
        q_bit    = (shifted >= {2'b00, dvsr});
        diff     = shifted[WIDTH:0] - {1'b0, dvsr};
        rem_next = q_bit ? diff : shifted[WIDTH:0];
    end

endmodule

// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiply (shift-add) / divide (restoring) beside the execute-stage ALU.
// Latency: ITER+1 edges from the start edge to the RDY pulse; divide-by-zero completes on the start edge.
// Backpressure: none; a new start at any time aborts the operation in flight without a RDY pulse.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CNT_W = $clog2(ITER + 1);

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   op_mag;      // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc;         // {partial product, remaining multiplier bits}
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   quo;         // dividend bits leave at the MSB, quotient bits enter at the LSB
    logic               neg_res;
    logic               div_ovf;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH:0]     prod_hi;
    logic               mul_ovf;
    logic [WIDTH-1:0]   quo_signed;
    logic [WIDTH:0]     step_rem;
    logic               step_q;
    logic               last_iter;

    restoring_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_cur  (rem),
        .dvd_bit  (quo[WIDTH-1]),
        .dvsr     (op_mag),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    always_comb begin
        mul_sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op_mag} : {(WIDTH+1){1'b0}});
        prod_signed = neg_res ? -acc : acc;
        prod_hi     = prod_signed[2*WIDTH-1:WIDTH-1];
        // Representable only if the upper W+1 bits are pure sign extension.
        mul_ovf     = !((&prod_hi) || !(|prod_hi));
        quo_signed  = neg_res ? -quo : quo;
        last_iter   = (count == CNT_W'(ITER));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            count          <= '0;
            op_mag         <= '0;
            acc            <= '0;
            rem            <= '0;
            quo            <= '0;
            neg_res        <= 1'b0;
            div_ovf        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else if (ctrl_MULT) begin
            state          <= MUL;
            count          <= '0;
            op_mag         <= twos_mag(data_operandA);
            acc            <= {{WIDTH{1'b0}}, twos_mag(data_operandB)};
            neg_res        <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            data_resultRDY <= 1'b0;
            busy           <= 1'b1;
        end else if (ctrl_DIV) begin
            if (data_operandB == '0) begin
                state          <= DONE;
                data_result    <= '0;
                data_exception <= 1'b1;
                data_resultRDY <= 1'b1;
                busy           <= 1'b0;
            end else begin
                state          <= DIV;
                count          <= '0;
                op_mag         <= twos_mag(data_operandB);
                quo            <= twos_mag(data_operandA);
                rem            <= '0;
                neg_res        <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                div_ovf        <= (data_operandA == MIN_INT) && (data_operandB == '1);
                data_resultRDY <= 1'b0;
                busy           <= 1'b1;
            end
        end else begin
            case (state)
                MUL: begin
                    if (last_iter) begin
                        state          <= DONE;
                        data_result    <= prod_signed[WIDTH-1:0];
                        data_exception <= mul_ovf;
                        data_resultRDY <= 1'b1;
                        busy           <= 1'b0;
                    end else begin
                        acc   <= {mul_sum, acc[WIDTH-1:1]};
                        count <= count + CNT_W'(1);
                    end
                end
                DIV: begin
                    if (last_iter) begin
                        state          <= DONE;
                        data_result    <= quo_signed;
                        data_exception <= div_ovf;
                        data_resultRDY <= 1'b1;
                        busy           <= 1'b0;
                    end else begin
                        rem   <= step_rem;
                        quo   <= {quo[WIDTH-2:0], step_q};
                        count <= count + CNT_W'(1);
                    end
                end
                DONE: begin
                    state          <= IDLE;
                    data_resultRDY <= 1'b0;
                end
                default: begin
                    state          <= IDLE;
                    data_resultRDY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed-vector bench for multdiv_unit with hand-computed results.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_multdiv_unit;

    logic        clock;
    logic        reset_n;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int checks;
    int errors;

    multdiv_unit #(
        .WIDTH (32),
        .ITER  (32)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pulse a start for one edge, then count falling edges until RDY (bounded).
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic m, input logic d, output int lat);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        lat = 0;
        while (!data_resultRDY && lat < 100) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic chk_done(input string tag, input int lat, input int exp_lat,
                            input logic [31:0] exp_res, input logic exp_exc);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_res"}, 64'(data_result), 64'(exp_res));
        chk({tag, "_exc"}, 64'(data_exception), 64'(exp_exc));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        @(negedge clock);
        chk({tag, "_rdy_drop"}, 64'(data_resultRDY), 64'd0);
        chk({tag, "_hold"}, 64'(data_result), 64'(exp_res));
    endtask

    initial begin
        int lat;
        int rdy_seen;
        checks         = 0;
        errors         = 0;
        reset_n        = 1'b0;
        data_operandA  = '0;
        data_operandB  = '0;
        ctrl_MULT      = 1'b0;
        ctrl_DIV       = 1'b0;

        repeat (2) @(negedge clock);
        chk("rst_res", 64'(data_result), 64'd0);
        chk("rst_exc", 64'(data_exception), 64'd0);
        chk("rst_rdy", 64'(data_resultRDY), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset_n = 1'b1;

        do_op(32'd7, 32'hFFFF_FFFA, 1'b1, 1'b0, lat);
        chk_done("mul_7x-6", lat, 33, 32'hFFFF_FFD6, 1'b0);

        // A new start must not disturb the held result until it completes.
        @(negedge clock);
        data_operandA = 32'h0001_0000;
        data_operandB = 32'h0001_0000;
        ctrl_MULT     = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_hold", 64'(data_result), 64'hFFFF_FFD6);
        lat = 0;
        while (!data_resultRDY && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        chk_done("mul_2^16sq", lat, 33, 32'h0000_0000, 1'b1);

        do_op(32'h7FFF_FFFF, 32'd1, 1'b1, 1'b0, lat);
        chk_done("mul_max_x1", lat, 33, 32'h7FFF_FFFF, 1'b0);

        do_op(32'h8000_0000, 32'd1, 1'b1, 1'b0, lat);
        chk_done("mul_min_x1", lat, 33, 32'h8000_0000, 1'b0);

        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, lat);
        chk_done("mul_min_xm1", lat, 33, 32'h8000_0000, 1'b1);

        do_op(32'hFFFF_FFEF, 32'd5, 1'b0, 1'b1, lat);
        chk_done("div_-17_5", lat, 33, 32'hFFFF_FFFD, 1'b0);

        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, lat);
        chk_done("div_min_m1", lat, 33, 32'h8000_0000, 1'b1);

        do_op(32'd123, 32'd0, 1'b0, 1'b1, lat);
        chk_done("div_by0", lat, 0, 32'h0000_0000, 1'b1);

        // Multiply aborted at cycle 10 by a divide; only the divide may report.
        do_op(32'd3, 32'd4, 1'b1, 1'b0, lat);
        chk("abort_no_early_rdy", 64'(lat), 64'd33);
        do_op(32'd0, 32'd0, 1'b0, 1'b0, lat);
        chk("dummy_wait_rdy_cleared", 64'(data_resultRDY), 64'd0);

        @(negedge clock);
        data_operandA = 32'd3;
        data_operandB = 32'd4;
        ctrl_MULT     = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        rdy_seen  = 0;
        for (int i = 1; i < 10; i++) begin
            @(negedge clock);
            if (data_resultRDY) rdy_seen++;
        end
        do_op(32'd100, 32'd7, 1'b0, 1'b1, lat);
        chk("abort_rdy_seen", 64'(rdy_seen), 64'd0);
        chk_done("restart_div", lat, 33, 32'd14, 1'b0);

        do_op(32'd6, 32'd3, 1'b1, 1'b1, lat);
        chk_done("both_start", lat, 33, 32'd18, 1'b0);

        // Asynchronous reset between clock edges during a divide.
        @(negedge clock);
        data_operandA = 32'd1000;
        data_operandB = 32'd3;
        ctrl_DIV      = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ctrl_DIV = 1'b0;
        repeat (5) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_res", 64'(data_result), 64'd0);
        chk("arst_exc", 64'(data_exception), 64'd0);
        chk("arst_rdy", 64'(data_resultRDY), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        rdy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (data_resultRDY || busy) rdy_seen++;
            if (i == 3) reset_n = 1'b1;
        end
        chk("arst_quiet", 64'(rdy_seen), 64'd0);

        do_op(32'd9, 32'd9, 1'b1, 1'b0, lat);
        chk_done("post_rst_mul", lat, 33, 32'd81, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
